// File: rtl/update_knn6_pkg.sv
// Shared definitions for the update_knn6 divider.
//   state_e        FSM state encoding (S_IDLE, S_CALC, S_DONE)
//   DEF_*          default operand widths
//   cnt_width()    width of the iteration step counter for a given quotient width
package update_knn6_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    localparam int unsigned DEF_DIVIDEND_WIDTH = 32;
    localparam int unsigned DEF_DIVISOR_WIDTH  = 15;
    localparam int unsigned DEF_QUO_WIDTH      = 17;

    // Counter holds QUO_WIDTH-1 down to 0; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_CNT_WIDTH = cnt_width(DEF_QUO_WIDTH);

endpackage

// File: rtl/update_knn6_div_seq_if.sv
// Handshake bundle for update_knn6_div_seq.
//   master: drives in_valid/dividend/divisor/out_ready, observes results
//   slave : the divider; drives in_ready/out_valid/quotient/remainder/flags
interface update_knn6_div_seq_if
    import update_knn6_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int unsigned DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int unsigned QUO_WIDTH      = DEF_QUO_WIDTH
);

    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [QUO_WIDTH-1:0]      quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/update_knn6_div_step.sv
// One radix-2 restoring division step (combinational).
//   rem      current partial remainder (always < divisor)
//   bit_in   next dividend bit, MSB first
//   divisor  divisor
//   rem_next partial remainder after the step
//   q_bit    quotient bit produced by the step
module update_knn6_div_step
    import update_knn6_pkg::*;
#(
    parameter int unsigned DIVISOR_WIDTH = DEF_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH-1:0] rem,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] rem_next,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH:0] trial;

    always_comb begin
        trial = {rem, bit_in};
        q_bit = (trial >= {1'b0, divisor});
        // When the subtract succeeds the true difference is < divisor, so the
        // low DIVISOR_WIDTH bits of the wrapped difference are exact.
        rem_next = q_bit ? (trial[DIVISOR_WIDTH-1:0] - divisor) : trial[DIVISOR_WIDTH-1:0];
    end

endmodule

// File: rtl/update_knn6_div_seq.sv
// Iterative radix-2 restoring unsigned divider: dividend / divisor -> quotient, remainder.
// One division in flight; valid/ready on both sides; ce freezes all state.
//   clk, reset (async, active-low), ce (clock enable)
//   bus (slave): in_valid/in_ready/dividend/divisor accept side,
//                out_valid/out_ready/quotient/remainder/div_by_zero/overflow result side
module update_knn6_div_seq
    import update_knn6_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int unsigned DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int unsigned QUO_WIDTH      = DEF_QUO_WIDTH
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 ce,
    update_knn6_div_seq_if.slave bus
);

    localparam int unsigned CNT_WIDTH = cnt_width(QUO_WIDTH);

    state_e                   state_q, state_d;
    logic [DIVISOR_WIDTH-1:0] rem_q, rem_d;
    logic [DIVISOR_WIDTH-1:0] div_q, div_d;
    // Holds the unconsumed low dividend bits at the top and the quotient
    // bits shifted in at the bottom; after QUO_WIDTH steps it is the quotient.
    logic [QUO_WIDTH-1:0]     quo_q, quo_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     dbz_q, dbz_d;
    logic                     ovf_q, ovf_d;

    logic [DIVISOR_WIDTH-1:0] hi;
    logic [DIVISOR_WIDTH-1:0] step_rem;
    logic                     step_q;

    // Fits DIVISOR_WIDTH because DIVIDEND_WIDTH <= QUO_WIDTH + DIVISOR_WIDTH.
    assign hi = DIVISOR_WIDTH'(bus.dividend >> QUO_WIDTH);

    update_knn6_div_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
        .rem     (rem_q),
        .bit_in  (quo_q[QUO_WIDTH-1]),
        .divisor (div_q),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    div_d = bus.divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end else if (hi >= bus.divisor) begin
                        state_d = S_DONE;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        rem_d   = hi;
                        quo_d   = bus.dividend[QUO_WIDTH-1:0];
                        cnt_d   = CNT_WIDTH'(QUO_WIDTH - 1);
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[QUO_WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
